// File: rtl/seq_divider8.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results are registered and held from the done pulse until the next accepted start.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] part_r;
  logic [CW-1:0]    count_r;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] next_part_s;
  logic             q_bit_s;

  // One restoring step; the subtract is WIDTH+1 wide, so its MSB is the borrow.
  always_comb begin
    shifted_s = {part_r, dvd_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_r};
    if (!trial_s[WIDTH]) begin
      q_bit_s     = 1'b1;
      next_part_s = trial_s[WIDTH-1:0];
    end else begin
      q_bit_s     = 1'b0;
      next_part_s = shifted_s[WIDTH-1:0];
    end
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      part_r      <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == {WIDTH{1'b0}}) begin
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              busy        <= 1'b0;
              done        <= 1'b1;
              state_r     <= DONE;
            end else begin
              dvd_r       <= dividend;
              dvs_r       <= divisor;
              part_r      <= {WIDTH{1'b0}};
              count_r     <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_r     <= RUN;
            end
          end
        end
        RUN: begin
          // Quotient bits shift into the vacated dividend LSBs.
          part_r  <= next_part_s;
          dvd_r   <= {dvd_r[WIDTH-2:0], q_bit_s};
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            quotient  <= {dvd_r[WIDTH-2:0], q_bit_s};
            remainder <= next_part_s;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
